// File: rtl/password_programmer.sv
// rtl/password_programmer.sv - captures, optionally confirms, and burst-commits a MAX_LEN-digit password
//
// Ports:
//   CLK, RST         clock (rising edge), asynchronous active-low reset
//   start            begin a programming session (sampled in S_IDLE only)
//   enable, digit    one digit per enable-high cycle
//   cancel           abort session while entering or confirming
//   data, address,   write port to the password store; non-zero only during
//   shouldWrite      the commit burst
//   busy             high outside S_IDLE
//   done, error      single-cycle pulses: commit finished / confirmation mismatch
module password_programmer #(
    parameter int DIGIT_W = 4,
    parameter int MAX_LEN = 4,
    parameter int ADDR_W  = $clog2(MAX_LEN),
    parameter bit CONFIRM = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               enable,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               cancel,
    output logic [DIGIT_W-1:0] data,
    output logic [ADDR_W-1:0]  address,
    output logic               shouldWrite,
    output logic               busy,
    output logic               done,
    output logic               error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTER,
        S_CONFIRM,
        S_COMMIT,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MAX_LEN - 1);

    state_t             state, state_nxt;
    logic [DIGIT_W-1:0] pw_buf [MAX_LEN];
    logic [ADDR_W-1:0]  idx;
    logic               mm;
    logic               error_q;

    // cancel has priority over a coincident enable, so that digit is dropped
    logic take_digit;
    logic at_last;
    logic final_mm;

    assign take_digit = enable && !cancel;
    assign at_last    = (idx == LAST_IDX);
    // mismatch including the digit arriving this cycle
    assign final_mm   = mm || (digit != pw_buf[idx]);

    // state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_ENTER;
            end
            S_ENTER: begin
                if (cancel) begin
                    state_nxt = S_IDLE;
                end else if (enable && at_last) begin
                    state_nxt = CONFIRM ? S_CONFIRM : S_COMMIT;
                end
            end
            S_CONFIRM: begin
                if (cancel) begin
                    state_nxt = S_IDLE;
                end else if (enable && at_last) begin
                    state_nxt = final_mm ? S_IDLE : S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (at_last) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // datapath: capture buffer, index, sticky mismatch, error pulse
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            idx     <= '0;
            mm      <= 1'b0;
            error_q <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                pw_buf[i] <= '0;
            end
        end else begin
            error_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx <= '0;
                        mm  <= 1'b0;
                    end
                end
                S_ENTER: begin
                    if (take_digit) begin
                        pw_buf[idx] <= digit;
                        idx         <= at_last ? '0 : idx + ADDR_W'(1);
                    end
                end
                S_CONFIRM: begin
                    if (take_digit) begin
                        mm  <= final_mm;
                        idx <= at_last ? '0 : idx + ADDR_W'(1);
                        if (at_last) error_q <= final_mm;
                    end
                end
                S_COMMIT: begin
                    idx <= at_last ? '0 : idx + ADDR_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // outputs decoded from state/idx so a reset clears them immediately
    always_comb begin
        shouldWrite = (state == S_COMMIT);
        address     = '0;
        data        = '0;
        if (state == S_COMMIT) begin
            address = idx;
            data    = pw_buf[idx];
        end
        busy  = (state != S_IDLE);
        done  = (state == S_DONE);
        error = error_q;
    end

endmodule
